std_sram_singleport_arbiter: RTL and testbench

N-requester arbiter that shares one single-port SRAM and its registered-output stage, one access per cycle. It accepts read/write requests on a valid/ready handshake, drives the SRAM control bus, and returns read data tagged with the requester index after the fixed two-cycle SRAM-plus-output-DFF latency. It sits between cache/MMU clients and a `std_sram_singleport_dffra` instance.

---
 rtl/std_sram_singleport_arbiter_pkg.sv | 27 ++
 rtl/std_sram_singleport_arbiter_picker.sv | 38 +++
 rtl/std_sram_singleport_arbiter.sv | 124 ++++++++++++
 tb/tb_std_sram_singleport_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/std_sram_singleport_arbiter_pkg.sv
// ============================================================================
// std_sram_singleport_arbiter_pkg : shared tag layout and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package std_sram_singleport_arbiter_pkg;

    // Tag = {id, is_write, is_read}; id occupies the upper ID_WIDTH bits.
    localparam int TAG_IS_READ  = 0;
    localparam int TAG_IS_WRITE = 1;
    localparam int TAG_ID_LSB   = 2;

    function automatic int tag_width(input int id_width);
        return TAG_ID_LSB + id_width;
    endfunction

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/std_sram_singleport_arbiter_picker.sv
// ============================================================================
// std_sram_arb_picker : rotating-priority picker, search upward from start
// Rev 1.0
// ============================================================================
`default_nettype none

module std_sram_arb_picker #(
    parameter int NUM_REQ  = 2,
    parameter int ID_WIDTH = 1
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] start,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any
);

    always_comb begin
        int pos;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(start) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any && valid[i] && (i == pos)) begin
                    any      = 1'b1;
                    grant[i] = 1'b1;
                    idx      = ID_WIDTH'(i);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/std_sram_singleport_arbiter.sv
// ============================================================================
// std_sram_singleport_arbiter : N-requester arbiter for one single-port SRAM
// with 2-cycle read-response and 1-cycle write-ack tag pipeline.
// Option macro: STD_SRAM_ARB_ROUND_ROBIN_EN (round-robin; else fixed priority)
// Rev 1.0
// ============================================================================
`default_nettype none

module std_sram_singleport_arbiter
    import std_sram_singleport_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int ID_WIDTH   = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
    output logic                          sram_en,
    output logic                          sram_we,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic [DATA_WIDTH-1:0]         sram_din,
    input  logic [DATA_WIDTH-1:0]         sram_dout,
    output logic                          rsp_valid,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          wack_valid,
    output logic [ID_WIDTH-1:0]           wack_id
);

    localparam int TAG_W = tag_width(ID_WIDTH);

    logic [NUM_REQ-1:0]  valid_gated;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_WIDTH-1:0] grant_idx;
    logic                grant_any;
    logic [ID_WIDTH-1:0] start_ptr;
    logic [TAG_W-1:0]    stage1_d, stage1_q;
    logic [TAG_W-1:0]    stage2_d, stage2_q;

    // Grants are suppressed while reset is asserted, even though they are combinational.
    assign valid_gated = resetn ? req_valid : '0;

`ifdef STD_SRAM_ARB_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0] rr_ptr_d, rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            if (grant_idx == ID_WIDTH'(NUM_REQ - 1)) rr_ptr_d = '0;
            else                                     rr_ptr_d = grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) rr_ptr_q <= '0;
        else         rr_ptr_q <= rr_ptr_d;
    end

    assign start_ptr = rr_ptr_q;
`else
    assign start_ptr = '0;
`endif

    std_sram_arb_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .valid (valid_gated),
        .start (start_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign req_ready = grant;
    assign sram_en   = grant_any;

    // One-hot AND-OR mux; all-zero when nobody is granted.
    always_comb begin
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sram_we   = req_we[i];
                sram_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sram_din  = req_din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        stage1_d                 = '0;
        stage1_d[TAG_IS_READ]    = grant_any & ~sram_we;
        stage1_d[TAG_IS_WRITE]   = grant_any &  sram_we;
        stage1_d[TAG_W-1:TAG_ID_LSB] = grant_idx;
        stage2_d                 = stage1_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign rsp_valid  = stage2_q[TAG_IS_READ];
    assign rsp_id     = stage2_q[TAG_W-1:TAG_ID_LSB];
    assign rsp_data   = sram_dout;
    assign wack_valid = stage1_q[TAG_IS_WRITE];
    assign wack_id    = stage1_q[TAG_W-1:TAG_ID_LSB];

endmodule

`default_nettype wire

// File: tb/tb_std_sram_singleport_arbiter.sv
// ============================================================================
// tb_std_sram_singleport_arbiter : directed bench with behavioural 2-cycle SRAM
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_std_sram_singleport_arbiter;

    localparam int C_NR = 4;
    localparam int C_AW = 4;
    localparam int C_DW = 8;
    localparam int C_IW = 2;

    logic                 clk;
    logic                 resetn;
    logic [C_NR-1:0]      req_valid;
    logic [C_NR-1:0]      req_ready;
    logic [C_NR-1:0]      req_we;
    logic [C_NR*C_AW-1:0] req_addr;
    logic [C_NR*C_DW-1:0] req_din;
    logic                 sram_en, sram_we;
    logic [C_AW-1:0]      sram_addr;
    logic [C_DW-1:0]      sram_din, sram_dout;
    logic                 rsp_valid, wack_valid;
    logic [C_IW-1:0]      rsp_id, wack_id;
    logic [C_DW-1:0]      rsp_data;

    int n_checks;
    int n_fail;

    std_sram_singleport_arbiter #(
        .NUM_REQ(C_NR), .ADDR_WIDTH(C_AW), .DATA_WIDTH(C_DW), .ID_WIDTH(C_IW)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_din(req_din),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .wack_valid(wack_valid), .wack_id(wack_id)
    );

    // SRAM macro plus output DFF: read data appears two edges after the access.
    logic [C_DW-1:0] mem [0:(1<<C_AW)-1];
    logic [C_DW-1:0] rd_q;

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_din;
            else         rd_q <= mem[sram_addr];
        end
        sram_dout <= rd_q;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [C_AW-1:0] a, input logic [C_DW-1:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*C_AW +: C_AW] = a;
        req_din[i*C_DW +: C_DW]  = d;
    endtask

    logic [C_NR-1:0] exp_g [0:5];
    int              exp_id [0:5];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rd_q      = '0;
        sram_dout = '0;
        for (int i = 0; i < (1 << C_AW); i++) mem[i] = C_DW'(8'h30 + i);
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_din   = '0;

        // Reset with every requester asking
        resetn = 1'b0;
        for (int i = 0; i < C_NR; i++) set_req(i, 1'b1, 1'b0, C_AW'(i), '0);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_en", 32'(sram_en), 32'h0);
        step();
        step();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_wack_valid", 32'(wack_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_wack_id", 32'(wack_id), 32'h0);

        // Release: first grant goes to requester 0 (read addr 0)
        resetn = 1'b1;
        #1;
        chk("rel_ready", 32'(req_ready), 32'h1);
        chk("rel_addr", 32'(sram_addr), 32'h0);
        step();
        req_valid = '0;
        #1;
        chk("rel_rsp_t1", 32'(rsp_valid), 32'h0);
        step();
        chk("rel_rsp_t2", 32'(rsp_valid), 32'h1);
        chk("rel_rsp_id", 32'(rsp_id), 32'h0);
        chk("rel_rsp_data", 32'(rsp_data), 32'h30);

        // Write 0xA5 to addr 5 from req1, read it back next cycle
        set_req(1, 1'b1, 1'b1, 4'd5, 8'hA5);
        #1;
        chk("wr_ready", 32'(req_ready), 32'h2);
        chk("wr_bus", {sram_en, sram_we, 2'b0, sram_addr, sram_din}, {1'b1, 1'b1, 2'b0, 4'd5, 8'hA5});
        step();
        chk("wr_wack_valid", 32'(wack_valid), 32'h1);
        chk("wr_wack_id", 32'(wack_id), 32'h1);
        set_req(1, 1'b1, 1'b0, 4'd5, 8'h00);
        #1;
        chk("raw_ready", 32'(req_ready), 32'h2);
        chk("raw_we", 32'(sram_we), 32'h0);
        step();
        req_valid = '0;
        #1;
        chk("raw_rsp_t1", 32'(rsp_valid), 32'h0);
        chk("raw_wack_none", 32'(wack_valid), 32'h0);
        step();
        chk("raw_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("raw_rsp_id", 32'(rsp_id), 32'h1);
        chk("raw_rsp_data", 32'(rsp_data), 32'hA5);
        step();
        chk("raw_rsp_pulse", 32'(rsp_valid), 32'h0);

        // Contention between req0 (addr 0) and req1 (addr 1) for six cycles
        for (int c = 0; c < 6; c++) begin
`ifdef STD_SRAM_ARB_ROUND_ROBIN_EN
            exp_g[c]  = (c % 2 == 0) ? 4'b0001 : 4'b0010;
            exp_id[c] = c % 2;
`else
            exp_g[c]  = 4'b0001;
            exp_id[c] = 0;
`endif
        end
        set_req(0, 1'b1, 1'b0, 4'd0, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'd1, 8'h00);
        for (int c = 0; c < 8; c++) begin
            if (c == 6) req_valid = '0;
            #1;
            if (c < 6) chk($sformatf("cont_grant%0d", c), 32'(req_ready), 32'(exp_g[c]));
            if (c >= 2) begin
                chk($sformatf("cont_rsp_id%0d", c), {31'(rsp_id), rsp_valid}, {31'(exp_id[c-2]), 1'b1});
                chk($sformatf("cont_rsp_data%0d", c), 32'(rsp_data), 32'(8'h30 + exp_id[c-2]));
            end
            step();
        end

        // Back-to-back reads of addresses 0..3 from req0
        for (int c = 0; c < 6; c++) begin
            if (c < 4) set_req(0, 1'b1, 1'b0, C_AW'(c), 8'h00);
            else       req_valid = '0;
            #1;
            if (c < 4) chk($sformatf("b2b_grant%0d", c), 32'(req_ready), 32'h1);
            if (c >= 2) chk($sformatf("b2b_rsp%0d", c - 2), {23'(rsp_data), rsp_valid},
                            {23'(8'h30 + c - 2), 1'b1});
            step();
        end
        chk("b2b_end", 32'(rsp_valid), 32'h0);

        // Wrap: grant 3 (write), then all valid -> requester 0
        set_req(3, 1'b1, 1'b1, 4'd7, 8'h77);
        #1;
        chk("wrap_g3", 32'(req_ready), 32'h8);
        step();
        chk("wrap_wack", {30'(wack_id), wack_valid}, {30'd3, 1'b1});
        for (int i = 0; i < C_NR; i++) set_req(i, 1'b1, 1'b0, C_AW'(i), 8'h00);
        #1;
        chk("wrap_next", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step();
        step();

        // Reset while a read from req2 is in flight
        set_req(2, 1'b1, 1'b0, 4'd7, 8'h00);
        #1;
        chk("mid_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        resetn    = 1'b0;
        step();
        chk("mid_rsp_t2", 32'(rsp_valid), 32'h0);
        resetn = 1'b1;
        step();
        chk("mid_rsp_t3", 32'(rsp_valid), 32'h0);

        // Write issued before the reset survives
        set_req(2, 1'b1, 1'b0, 4'd7, 8'h00);
        step();
        req_valid = '0;
        step();
        chk("post_rst_rsp", {23'(rsp_data), rsp_valid}, {23'h77, 1'b1});
        chk("post_rst_id", 32'(rsp_id), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
